// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout,s} = a + b + cin, with signed-overflow flag.
// Latency: one clock; inputs sampled on a rising edge appear on the outputs after that edge.
// Backpressure: none; a new input set is accepted and a result produced on every clock.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             valid
);

  // One bit cell: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    logic sum_bit;
    logic carry_bit;
    sum_bit   = x ^ y ^ c;
    carry_bit = (x & y) | (x & c) | (y & c);
    return {carry_bit, sum_bit};
  endfunction

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_n;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  // Ripple the carry through the bit cells from LSB to MSB.
  always_comb begin
    carry    = '0;
    sum_n    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      {carry[i+1], sum_n[i]} = fa(a[i], b[i], carry[i]);
    end
  end

  // Next-state values for the output registers. Overflow compares the carry
  // into the MSB with the carry out of it; for WIDTH=1 the carry in is cin.
  always_comb begin
    s_d     = sum_n;
    cout_d  = carry[WIDTH];
    ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
    valid_d = 1'b1;
  end

  // Output registers; reset wins over the sampled inputs and drops any result in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign s     = s_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1, b1, cin1, s1, cout1, ovf1, valid1;
  logic [3:0] a4, b4, s4;
  logic       cin4, cout4, ovf4, valid4;
  logic [7:0] a8, b8, s8;
  logic       cin8, cout8, ovf8, valid8;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .ovf(ovf1), .valid(valid1)
  );

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .ovf(ovf4), .valid(valid4)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .ovf(ovf8), .valid(valid8)
  );

  // Reference model: plain integer addition and signed range check.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic r);
    exp_t        e;
    logic [64:0] tot;
    logic [63:0] mask;
    longint      sa, sb, tr, smax, smin;
    e.s = '0; e.cout = 1'b0; e.ovf = 1'b0; e.valid = 1'b0;
    if (r) return e;
    tot  = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    mask = (64'd1 << w) - 64'd1;
    e.s     = tot[63:0] & mask;
    e.cout  = tot[w];
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    tr   = sa + sb + longint'(cin);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    e.ovf   = (tr > smax) || (tr < smin);
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_one(input string name, input exp_t e, input logic [63:0] s_o,
                         input logic c_o, input logic o_o, input logic v_o);
    chk({name, ".s"},     s_o,          e.s);
    chk({name, ".cout"},  64'(c_o),     64'(e.cout));
    chk({name, ".ovf"},   64'(o_o),     64'(e.ovf));
    chk({name, ".valid"}, 64'(v_o),     64'(e.valid));
  endtask

  // Push expectations for the current inputs, clock once, then pop and compare.
  task automatic tick();
    exp_t e;
    q1.push_back(model(1, 64'(a1), 64'(b1), cin1, rst));
    q4.push_back(model(4, 64'(a4), 64'(b4), cin4, rst));
    q8.push_back(model(8, 64'(a8), 64'(b8), cin8, rst));
    @(posedge clk);
    #1;
    if (q1.size() == 0 || q4.size() == 0 || q8.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q1.pop_front(); chk_one("w1", e, 64'(s1), cout1, ovf1, valid1);
      e = q4.pop_front(); chk_one("w4", e, 64'(s4), cout4, ovf4, valid4);
      e = q8.pop_front(); chk_one("w8", e, 64'(s8), cout8, ovf8, valid8);
    end
  endtask

  task automatic rand_all();
    a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); cin1 = 1'($urandom_range(0, 1));
    a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15)); cin4 = 1'($urandom_range(0, 1));
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); cin8 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [2:0] v;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;

    // Reset held two cycles with all-ones inputs: outputs must stay zero.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // WIDTH=1 directed sweep; first step also shows valid rising.
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; tick();
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; tick();
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b1; tick();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; tick();

    // WIDTH=1 exhaustive, back to back, with random traffic on the wider adders.
    for (int i = 0; i < 8; i++) begin
      rand_all();
      v = 3'(i);
      {a1, b1, cin1} = v;
      tick();
    end

    // WIDTH=4 carry ripple through every bit, and signed overflow without carry.
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; tick();
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; tick();

    // WIDTH=8 extremes.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; tick();
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; tick();

    // Mid-stream reset pulse on a steady A+5+1 stream.
    a4 = 4'hA; b4 = 4'h5; cin4 = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Randomized traffic on all widths.
    for (int i = 0; i < 1000; i++) begin
      rand_all();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
